// File: rtl/piano_tone_pkg.sv
// Shared types and constants for the buzzer note scheduler.
// Holds the FSM state encoding, field widths and the pitch half-period table.
package piano_tone_pkg;

    localparam int PITCH_W = 4;
    localparam int DUR_W   = 8;
    localparam int HALF_W  = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Half-period of each pitch in microseconds; 0 marks a rest.
    function automatic logic [HALF_W-1:0] half_us(
        input logic [PITCH_W-1:0] pitch
    );
        logic [HALF_W-1:0] h;
        case (pitch)
            4'd1:    h = 11'd1911;
            4'd2:    h = 11'd1703;
            4'd3:    h = 11'd1517;
            4'd4:    h = 11'd1432;
            4'd5:    h = 11'd1276;
            4'd6:    h = 11'd1136;
            4'd7:    h = 11'd1012;
            4'd8:    h = 11'd956;
            4'd9:    h = 11'd851;
            4'd10:   h = 11'd758;
            4'd11:   h = 11'd716;
            4'd12:   h = 11'd638;
            4'd13:   h = 11'd568;
            4'd14:   h = 11'd506;
            default: h = '0;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/tick_gen_us_ms.sv
// Microsecond and millisecond tick generator with synchronous clear.
// Ports: clk, rst (sync, active-high), clr (restart phase), us_tick, ms_tick.
module tick_gen_us_ms #(
    parameter int CLK_PER_US = 100,
    parameter int US_PER_MS  = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic us_tick,
    output logic ms_tick
);

    // A divide-by-1 still needs one bit of storage.
    localparam int PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int US_W  = (US_PER_MS > 1) ? $clog2(US_PER_MS) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_US - 1);
    localparam logic [US_W-1:0]  US_LAST  = US_W'(US_PER_MS - 1);

    logic [PRE_W-1:0] pre;
    logic [US_W-1:0]  us_cnt;

    assign us_tick = (pre == PRE_LAST);
    assign ms_tick = us_tick & (us_cnt == US_LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pre    <= '0;
            us_cnt <= '0;
        end else if (us_tick) begin
            pre    <= '0;
            us_cnt <= ms_tick ? '0 : us_cnt + 1'b1;
        end else begin
            pre    <= pre + 1'b1;
        end
    end

endmodule

// File: rtl/note_tone_scheduler.sv
// Plays one note at a time on the buzzer: square wave, then a silent gap.
// Ports: clk, rst, req_valid/req_ready/req_pitch/req_dur_ms request handshake,
// stop abort, tone_out buzzer drive, busy, note_done pulse, cur_pitch.
module note_tone_scheduler
    import piano_tone_pkg::*;
#(
    parameter int CLK_PER_US = 100,
    parameter int US_PER_MS  = 1000,
    parameter int GAP_MS     = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [PITCH_W-1:0] req_pitch,
    input  logic [DUR_W-1:0]   req_dur_ms,
    input  logic               stop,
    output logic               tone_out,
    output logic               busy,
    output logic               note_done,
    output logic [PITCH_W-1:0] cur_pitch
);

    localparam bit NO_GAP = (GAP_MS == 0);
    localparam logic [DUR_W-1:0] GAP_LAST =
        (GAP_MS > 0) ? DUR_W'(GAP_MS - 1) : '0;

    state_t             state, state_n;
    logic [PITCH_W-1:0] pitch_q, pitch_n;
    logic [DUR_W-1:0]   dur_q, dur_n;
    logic [DUR_W-1:0]   ms_cnt, ms_n;
    logic [HALF_W-1:0]  half_cnt, half_n;
    logic               tone_q, tone_n;
    logic               done_q, done_n;
    logic               tick_clr;
    logic               us_tick, ms_tick;
    logic               accept;
    logic [HALF_W-1:0]  half;

    tick_gen_us_ms #(
        .CLK_PER_US (CLK_PER_US),
        .US_PER_MS  (US_PER_MS)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .clr     (tick_clr),
        .us_tick (us_tick),
        .ms_tick (ms_tick)
    );

    assign req_ready = (state == IDLE) & ~stop;
    assign accept    = req_valid & req_ready;
    assign half      = half_us(pitch_q);

    assign tone_out  = tone_q;
    assign busy      = (state != IDLE);
    assign note_done = done_q;
    assign cur_pitch = pitch_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pitch_q  <= '0;
            dur_q    <= '0;
            ms_cnt   <= '0;
            half_cnt <= '0;
            tone_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            pitch_q  <= pitch_n;
            dur_q    <= dur_n;
            ms_cnt   <= ms_n;
            half_cnt <= half_n;
            tone_q   <= tone_n;
            done_q   <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        pitch_n  = pitch_q;
        dur_n    = dur_q;
        ms_n     = ms_cnt;
        half_n   = half_cnt;
        tone_n   = tone_q;
        done_n   = 1'b0;
        tick_clr = 1'b0;

        unique case (state)
            IDLE: begin
                tone_n = 1'b0;
                if (accept) begin
                    state_n  = PLAY;
                    pitch_n  = req_pitch;
                    dur_n    = (req_dur_ms == '0) ? DUR_W'(1) : req_dur_ms;
                    ms_n     = '0;
                    half_n   = '0;
                    tick_clr = 1'b1;
                end
            end
            PLAY: begin
                if (us_tick) begin
                    // Rests keep the wave low but still time out normally.
                    if (half == '0) begin
                        tone_n = 1'b0;
                        half_n = '0;
                    end else if (half_cnt == half - 1'b1) begin
                        tone_n = ~tone_q;
                        half_n = '0;
                    end else begin
                        half_n = half_cnt + 1'b1;
                    end
                end
                if (ms_tick) begin
                    // Compare against dur-1 so dur=255 never wraps ms_cnt.
                    if (ms_cnt == dur_q - 1'b1) begin
                        tone_n = 1'b0;
                        half_n = '0;
                        ms_n   = '0;
                        if (NO_GAP) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                            pitch_n = '0;
                        end else begin
                            state_n = GAP;
                        end
                    end else begin
                        ms_n = ms_cnt + 1'b1;
                    end
                end
            end
            GAP: begin
                tone_n = 1'b0;
                if (ms_tick) begin
                    if (ms_cnt == GAP_LAST) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        pitch_n = '0;
                        ms_n    = '0;
                    end else begin
                        ms_n = ms_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tone_n  = 1'b0;
                pitch_n = '0;
            end
        endcase

        // Abort wins over every in-flight transition, including completion.
        if (stop && (state != IDLE)) begin
            state_n = IDLE;
            pitch_n = '0;
            ms_n    = '0;
            half_n  = '0;
            tone_n  = 1'b0;
            done_n  = 1'b0;
        end
    end

endmodule
